// File: rtl/game_ctrl.sv
// Flappy Bird game sequencer: IDLE/PLAY/HIT/OVER state machine, run/load
// enables for bird and pipes, flap key conditioning, and BCD score/best.
module game_ctrl #(
    parameter int TICK_DIV  = 1485000,
    parameter int HIT_TICKS = 50,
    parameter int Y_GROUND  = 700
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_flap,
    input  logic [11:0] bpos_y,
    input  logic        collide,
    input  logic        pipe_passed,
    output logic [1:0]  state,
    output logic        bird_run,
    output logic        bird_load,
    output logic        pipe_run,
    output logic        pipe_load,
    output logic        flap,
    output logic [11:0] score,
    output logic [11:0] best
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int HIT_W = $clog2(HIT_TICKS + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PLAY = 2'd1,
        S_HIT  = 2'd2,
        S_OVER = 2'd3
    } state_t;

    state_t             state_q;
    state_t             state_nxt;
    logic               key_s1;
    logic               key_s2;
    logic               key_prev;
    logic               flap_edge;
    logic               crash;
    logic               tick;
    logic [CNT_W-1:0]   tick_cnt;
    logic [HIT_W-1:0]   hit_cnt;

    // Saturating 3-digit BCD increment; 999 holds.
    function automatic logic [11:0] bcd_inc(input logic [11:0] s);
        logic [11:0] r;
        r = s;
        if (s != 12'h999) begin
            if (s[3:0] == 4'd9) begin
                r[3:0] = 4'd0;
                if (s[7:4] == 4'd9) begin
                    r[7:4]  = 4'd0;
                    r[11:8] = s[11:8] + 4'd1;
                end else begin
                    r[7:4] = s[7:4] + 4'd1;
                end
            end else begin
                r[3:0] = s[3:0] + 4'd1;
            end
        end
        return r;
    endfunction

    assign state     = state_q;
    assign flap_edge = key_s2 & ~key_prev;
    assign crash     = collide | (bpos_y >= 12'(Y_GROUND));
    assign tick      = (tick_cnt == CNT_W'(TICK_DIV - 1));

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_IDLE: if (flap_edge) state_nxt = S_PLAY;
            S_PLAY: if (crash) state_nxt = S_HIT;
            S_HIT:  if (tick && hit_cnt == HIT_W'(HIT_TICKS - 1)) state_nxt = S_OVER;
            S_OVER: if (flap_edge) state_nxt = S_IDLE;
        endcase
    end

    // Outputs are decoded from state_nxt so they switch on the same edge as state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            key_s1    <= 1'b0;
            key_s2    <= 1'b0;
            key_prev  <= 1'b0;
            tick_cnt  <= '0;
            hit_cnt   <= '0;
            bird_run  <= 1'b0;
            pipe_run  <= 1'b0;
            bird_load <= 1'b1;
            pipe_load <= 1'b1;
            flap      <= 1'b0;
            score     <= 12'h000;
            best      <= 12'h000;
        end else begin
            key_s1    <= key_flap;
            key_s2    <= key_s1;
            key_prev  <= key_s2;
            tick_cnt  <= tick ? '0 : tick_cnt + 1'b1;
            state_q   <= state_nxt;
            bird_run  <= (state_nxt == S_PLAY);
            pipe_run  <= (state_nxt == S_PLAY);
            bird_load <= (state_nxt == S_IDLE);
            pipe_load <= (state_nxt == S_IDLE);
            flap      <= (state_nxt == S_PLAY) & key_s2;
            case (state_q)
                S_IDLE: if (state_nxt == S_PLAY) score <= 12'h000;
                S_PLAY: begin
                    // A crash in the same clock as pipe_passed takes priority.
                    if (state_nxt == S_HIT) hit_cnt <= '0;
                    else if (pipe_passed)   score <= bcd_inc(score);
                end
                S_HIT: begin
                    if (tick) begin
                        if (state_nxt == S_OVER) begin
                            if (score > best) best <= score;
                        end else begin
                            hit_cnt <= hit_cnt + 1'b1;
                        end
                    end
                end
                S_OVER: ;
            endcase
        end
    end

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a short tick (TICK_DIV=4, HIT_TICKS=3).
module tb_game_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_flap = 1'b0;
    logic [11:0] bpos_y = 12'd0;
    logic        collide = 1'b0;
    logic        pipe_passed = 1'b0;
    logic [1:0]  state;
    logic        bird_run, bird_load, pipe_run, pipe_load, flap;
    logic [11:0] score, best;

    int checks = 0;
    int errors = 0;

    game_ctrl #(.TICK_DIV(4), .HIT_TICKS(3), .Y_GROUND(700)) dut (
        .clk(clk), .rst_n(rst_n), .key_flap(key_flap), .bpos_y(bpos_y),
        .collide(collide), .pipe_passed(pipe_passed), .state(state),
        .bird_run(bird_run), .bird_load(bird_load), .pipe_run(pipe_run),
        .pipe_load(pipe_load), .flap(flap), .score(score), .best(best)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key;
        key_flap = 1'b1;
        step(3);
        key_flap = 1'b0;
        step(3);
    endtask

    task automatic pulses(input int n);
        pipe_passed = 1'b1;
        step(n);
        pipe_passed = 1'b0;
    endtask

    task automatic wait_over(output int n);
        n = 0;
        while (state !== 2'd3 && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        step(2);
        rst_n = 1'b1;
        checks++;
        if (state !== 2'd0 || bird_load !== 1'b1 || pipe_load !== 1'b1 ||
            bird_run !== 1'b0 || pipe_run !== 1'b0 || flap !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: state=%0d bl=%b pl=%b br=%b pr=%b flap=%b, want 0 1 1 0 0 0",
                     state, bird_load, pipe_load, bird_run, pipe_run, flap);
        end
        checks++;
        if (score !== 12'h000 || best !== 12'h000) begin
            errors++;
            $display("FAIL reset_score: score=%h best=%h, want 000 000", score, best);
        end
    endtask

    task automatic test_start;
        key_flap = 1'b1;
        step(2);
        checks++;
        if (state !== 2'd0) begin
            errors++;
            $display("FAIL start_latency: state=%0d at n+2, want 0", state);
        end
        step();
        checks++;
        if (state !== 2'd1 || bird_run !== 1'b1 || pipe_run !== 1'b1 ||
            bird_load !== 1'b0 || pipe_load !== 1'b0 || score !== 12'h000 || flap !== 1'b1) begin
            errors++;
            $display("FAIL start_play: state=%0d br=%b pr=%b bl=%b pl=%b score=%h flap=%b, want 1 1 1 0 0 000 1",
                     state, bird_run, pipe_run, bird_load, pipe_load, score, flap);
        end
        step(17);
        checks++;
        if (state !== 2'd1 || flap !== 1'b1) begin
            errors++;
            $display("FAIL start_hold: state=%0d flap=%b, want 1 1", state, flap);
        end
        key_flap = 1'b0;
        step(3);
        checks++;
        if (state !== 2'd1 || flap !== 1'b0) begin
            errors++;
            $display("FAIL start_release: state=%0d flap=%b, want 1 0", state, flap);
        end
    endtask

    task automatic test_score;
        pulses(12);
        step();
        checks++;
        if (score !== 12'h012) begin
            errors++;
            $display("FAIL score_12: score=%h, want 012", score);
        end
        pulses(987);
        step();
        checks++;
        if (score !== 12'h999) begin
            errors++;
            $display("FAIL score_999: score=%h, want 999", score);
        end
        pulses(1);
        step();
        checks++;
        if (score !== 12'h999 || state !== 2'd1) begin
            errors++;
            $display("FAIL score_saturate: score=%h state=%0d, want 999 1", score, state);
        end
    endtask

    task automatic test_crash_tie;
        int n;
        pulses(5);
        collide = 1'b1;
        pipe_passed = 1'b1;
        step();
        collide = 1'b0;
        pipe_passed = 1'b0;
        checks++;
        if (state !== 2'd2 || score !== 12'h005 || bird_run !== 1'b0 || pipe_run !== 1'b0 ||
            bird_load !== 1'b0 || pipe_load !== 1'b0) begin
            errors++;
            $display("FAIL crash_tie: state=%0d score=%h br=%b pr=%b bl=%b pl=%b, want 2 005 0 0 0 0",
                     state, score, bird_run, pipe_run, bird_load, pipe_load);
        end
        key_flap = 1'b1;
        wait_over(n);
        checks++;
        if (state !== 2'd3 || n < 9 || n > 12 || best !== 12'h005 || flap !== 1'b0) begin
            errors++;
            $display("FAIL hit_duration: state=%0d clocks=%0d best=%h flap=%b, want 3 9..12 005 0",
                     state, n, best, flap);
        end
        step(5);
        checks++;
        if (state !== 2'd3) begin
            errors++;
            $display("FAIL held_key_over: state=%0d, want 3", state);
        end
        key_flap = 1'b0;
        step(3);
    endtask

    task automatic test_best;
        int n;
        press_key;
        checks++;
        if (state !== 2'd0 || bird_load !== 1'b1 || pipe_load !== 1'b1) begin
            errors++;
            $display("FAIL over_to_idle: state=%0d bl=%b pl=%b, want 0 1 1", state, bird_load, pipe_load);
        end
        press_key;
        checks++;
        if (state !== 2'd1 || score !== 12'h000) begin
            errors++;
            $display("FAIL restart: state=%0d score=%h, want 1 000", state, score);
        end
        pulses(3);
        bpos_y = 12'd700;
        step();
        bpos_y = 12'd0;
        checks++;
        if (state !== 2'd2 || score !== 12'h003) begin
            errors++;
            $display("FAIL ground_700: state=%0d score=%h, want 2 003", state, score);
        end
        wait_over(n);
        checks++;
        if (state !== 2'd3 || best !== 12'h005) begin
            errors++;
            $display("FAIL best_keep: state=%0d best=%h, want 3 005", state, best);
        end
        press_key;
        press_key;
        bpos_y = 12'd699;
        step(4);
        checks++;
        if (state !== 2'd1) begin
            errors++;
            $display("FAIL ground_699: state=%0d, want 1", state);
        end
        bpos_y = 12'd0;
        pulses(7);
        collide = 1'b1;
        step();
        collide = 1'b0;
        wait_over(n);
        checks++;
        if (state !== 2'd3 || best !== 12'h007 || score !== 12'h007) begin
            errors++;
            $display("FAIL best_update: state=%0d best=%h score=%h, want 3 007 007", state, best, score);
        end
    endtask

    task automatic test_reset_in_hit;
        int n;
        press_key;
        press_key;
        pulses(2);
        collide = 1'b1;
        step();
        collide = 1'b0;
        step(2);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (state !== 2'd0 || score !== 12'h000 || best !== 12'h000 || bird_load !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_hit: state=%0d score=%h best=%h bl=%b, want 0 000 000 1",
                     state, score, best, bird_load);
        end
        press_key;
        collide = 1'b1;
        step();
        collide = 1'b0;
        wait_over(n);
        checks++;
        if (state !== 2'd3 || n < 9 || n > 12) begin
            errors++;
            $display("FAIL hit_after_reset: state=%0d clocks=%0d, want 3 9..12", state, n);
        end
    endtask

    initial begin
        test_reset;
        test_start;
        test_score;
        test_reset;
        test_start;
        test_crash_tie;
        test_best;
        test_reset_in_hit;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/game_ctrl.md
Name: game_ctrl

Overview:
- Top-level game sequencer for the Flappy Bird datapath.
- Owns the play/idle/crash/game-over state machine and gates the bird physics and pipe scroller with run and load enables.
- Detects game-ending conditions from the pipe collision flag and the bird's ground position.
- Keeps the current and best BCD score for the display/HUD logic.

Parameters:
- TICK_DIV, 1485000: clocks per game tick (equals the bird move period).
- HIT_TICKS, 50: game ticks spent frozen in HIT before entering OVER.
- Y_GROUND, 700: bird y at or beyond which the bird has hit the ground.

Ports:
- clk  in  1  system/pixel clock
- rst_n  in  1  synchronous active-low reset
- key_flap  in  1  raw flap pushbutton level, asynchronous, active-high
- bpos_y  in  12  current bird y position from the bird block
- collide  in  1  level, bird overlaps a pipe (same clock domain)
- pipe_passed  in  1  one-clock pulse when a pipe's trailing edge passes the bird
- state  out  2  0=IDLE, 1=PLAY, 2=HIT, 3=OVER
- bird_run  out  1  bird physics enable
- bird_load  out  1  hold bird at its start position
- pipe_run  out  1  pipe scroll enable
- pipe_load  out  1  hold pipes at their initial layout
- flap  out  1  synchronized key level, gated to PLAY (drives the bird's up key)
- score  out  12  current score, 3 BCD digits
- best  out  12  best score since reset, 3 BCD digits

Behaviour:
- Reset (rst_n=0 at a clk edge) forces:
  - state=IDLE, bird_load=1, pipe_load=1.
  - bird_run=0, pipe_run=0, flap=0.
  - score=0, best=0.
  - Tick counter, hit timer and synchronizer flops cleared.
  - Reset mid-game behaves identically; best is lost.
- Key path: key_flap passes through a 2-flop synchronizer, then a rising-edge detector (sync level AND NOT previous sync level).
  - A press at clock n is detected at n+2.
  - The state changes at edge n+3.
  - A held key produces exactly one edge.
- Tick: free-running counter 0..TICK_DIV-1; tick pulses for one clock when the counter wraps. The tick is not reset by state changes.
- All outputs are registered and decoded from the next state, so they change on the same edge as state.
- IDLE:
  - bird_load=1, pipe_load=1, run outputs 0.
  - On a flap edge: go to PLAY and clear score to 000.
- PLAY:
  - bird_run=1, pipe_run=1, loads 0, flap=sync key level.
  - If collide=1 or bpos_y >= Y_GROUND (unsigned 12-bit compare): go to HIT and clear the hit timer.
  - Else if pipe_passed=1: BCD increment score. Each digit carries at 9->0. Score saturates at 999 (no wrap).
  - collide and pipe_passed in the same clock: the crash wins, score is unchanged.
  - Flap edges in PLAY do not change state.
- HIT:
  - All run outputs 0, loads 0, flap=0.
  - Each tick increments the hit timer.
  - When the timer reaches HIT_TICKS-1 and a tick occurs: go to OVER.
  - Duration is HIT_TICKS ticks; the first tick may be partial.
  - Flap edges are ignored.
- OVER:
  - Outputs same as HIT.
  - On the transition HIT->OVER, best <= score if score > best (BCD compares as unsigned binary).
  - On a flap edge: go to IDLE. A key held since HIT causes no edge, so no restart.
- Score and best are stable outside the listed update points.
- State encoding 3 is reachable only via HIT. There are no illegal codes in 2 bits.

Test Plan (TICK_DIV=4, HIT_TICKS=3, Y_GROUND=700):
- Reset, then press key_flap at cycle 10 and hold 20 cycles -> state=PLAY at edge 13, bird_run=pipe_run=1, loads=0, score=000; holding the key produces no further transitions.
- In PLAY, pulse pipe_passed 12 times -> score=0x012. Preload 999 via 999 pulses, then pulse once more -> score stays 0x999.
- In PLAY, assert collide and pipe_passed on the same clock with score=0x005 -> state=HIT next edge, score=0x005, bird_run=0. After 3 ticks (9-12 clocks) -> state=OVER, best=0x005.
- In PLAY, drive bpos_y=700 with collide=0 -> HIT. Repeat with bpos_y=699 -> stays PLAY.
- In OVER with best=0x005, play a round scoring 3 -> best stays 0x005. Then score 7 -> best=0x007. A flap edge in OVER -> IDLE with loads=1. A second flap edge -> PLAY with score=000.
- Assert rst_n=0 for one clock during HIT -> next edge state=IDLE, score=best=000, hit timer restarts cleanly on the next crash.
